// File: rtl/ip_wr_data.sv
`default_nettype none
// ============================================================================
// Module   : ip_wr_data
// Purpose  : Inner-product result writer for the FC engine. Takes output-
//            neuron results from the inner-product accumulator, applies ReLU
//            on hidden layers (0..4) and writes them to consecutive addresses
//            of the ping-pong activation BRAM. It also tracks the per-layer
//            neuron count, flips the bank at layer end, and raises a sticky
//            error flag on protocol violations.
// Ports    :
//   clk_i              in   1   clock, rising edge
//   rstn_i             in   1   asynchronous active-low reset
//   cur_layer_index_i  in   3   layer index, sampled on layer_start_i only
//   layer_start_i      in   1   one-cycle pulse arming a new layer
//   ip_result_valid_i  in   1   result word valid
//   ip_result_i        in   FW  neuron result (two's complement)
//   wr_en_o            out  1   BRAM write enable
//   wr_addr_o          out  AW  BRAM write address
//   wr_data_o          out  FW  BRAM write data
//   wr_bank_o          out  1   ping-pong bank being written
//   busy_o             out  1   high while armed for a layer
//   layer_done_o       out  1   one-cycle pulse after the last write
//   err_o              out  1   sticky protocol error
// Revision : 1.0 - initial release
// ============================================================================
module ip_wr_data #(
   parameter int FW = 32,
   parameter int AW = 15
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   input  logic [2:0]    cur_layer_index_i,
   input  logic          layer_start_i,
   input  logic          ip_result_valid_i,
   input  logic [FW-1:0] ip_result_i,
   output logic          wr_en_o,
   output logic [AW-1:0] wr_addr_o,
   output logic [FW-1:0] wr_data_o,
   output logic          wr_bank_o,
   output logic          busy_o,
   output logic          layer_done_o,
   output logic          err_o
);

   // Neuron position counter width; the write address is this counter
   // zero-extended to the BRAM address width.
   localparam int c_POS_W = 12;

   // Last neuron index of each layer (count minus one).
   localparam logic [c_POS_W-1:0] c_END_L0 = 12'd255;
   localparam logic [c_POS_W-1:0] c_END_L1 = 12'd4095;
   localparam logic [c_POS_W-1:0] c_END_L2 = 12'd255;
   localparam logic [c_POS_W-1:0] c_END_L3 = 12'd4095;
   localparam logic [c_POS_W-1:0] c_END_L4 = 12'd999;
   localparam logic [c_POS_W-1:0] c_END_L5 = 12'd999;
   localparam logic [c_POS_W-1:0] c_END_NA = 12'd0;

   // Last layer that gets ReLU; the classifier layer and the unused
   // indices pass results through untouched.
   localparam logic [2:0] c_LAST_RELU = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // ---------------------------------------------------------------------
   // Registered state
   // ---------------------------------------------------------------------
   state_t               r_state;
   logic [2:0]           r_layer;
   logic [c_POS_W-1:0]   r_neuron_pos;
   logic                 r_wr_en;
   logic [AW-1:0]        r_wr_addr;
   logic [FW-1:0]        r_wr_data;
   logic                 r_wr_bank;
   logic                 r_busy;
   logic                 r_layer_done;
   logic                 r_err;

   // ---------------------------------------------------------------------
   // Next-state values
   // ---------------------------------------------------------------------
   state_t               w_state_nxt;
   logic [2:0]           w_layer_nxt;
   logic [c_POS_W-1:0]   w_neuron_pos_nxt;
   logic                 w_wr_en_nxt;
   logic [AW-1:0]        w_wr_addr_nxt;
   logic [FW-1:0]        w_wr_data_nxt;
   logic                 w_wr_bank_nxt;
   logic                 w_err_nxt;

   logic [c_POS_W-1:0]   w_neuron_end;
   logic [FW-1:0]        w_result_fmt;

   // Layer length lookup, driven by the latched layer so that index changes
   // between start pulses cannot disturb a layer in progress.
   always_comb begin
      w_neuron_end = c_END_NA;
      case (r_layer)
         3'd0:    w_neuron_end = c_END_L0;
         3'd1:    w_neuron_end = c_END_L1;
         3'd2:    w_neuron_end = c_END_L2;
         3'd3:    w_neuron_end = c_END_L3;
         3'd4:    w_neuron_end = c_END_L4;
         3'd5:    w_neuron_end = c_END_L5;
         default: w_neuron_end = c_END_NA;
      endcase
   end

   // Hidden layers clamp negative results to zero.
   always_comb begin
      w_result_fmt = ip_result_i;
      if ((r_layer <= c_LAST_RELU) && ip_result_i[FW-1]) begin
         w_result_fmt = '0;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state / output logic
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt      = r_state;
      w_layer_nxt      = r_layer;
      w_neuron_pos_nxt = r_neuron_pos;
      w_wr_en_nxt      = 1'b0;
      w_wr_addr_nxt    = r_wr_addr;      // address holds between writes
      w_wr_data_nxt    = '0;             // data reads zero when not writing
      w_wr_bank_nxt    = r_wr_bank;
      w_err_nxt        = r_err;

      case (r_state)
         ST_IDLE: begin
            // A valid here (including one alongside the start pulse) has no
            // layer to belong to, so it is dropped.
            if (ip_result_valid_i) begin
               w_err_nxt = 1'b1;
            end
            if (layer_start_i) begin
               w_layer_nxt      = cur_layer_index_i;
               w_neuron_pos_nxt = '0;
               w_state_nxt      = ST_WRITE;
            end
         end

         ST_WRITE: begin
            if (layer_start_i) begin
               w_err_nxt = 1'b1;
            end
            if (ip_result_valid_i) begin
               w_wr_en_nxt   = 1'b1;
               w_wr_addr_nxt = {{(AW-c_POS_W){1'b0}}, r_neuron_pos};
               w_wr_data_nxt = w_result_fmt;
               if (r_neuron_pos == w_neuron_end) begin
                  w_neuron_pos_nxt = '0;
                  w_state_nxt      = ST_DONE;
               end else begin
                  w_neuron_pos_nxt = r_neuron_pos + 1'b1;
               end
            end
         end

         ST_DONE: begin
            // Single-cycle state: anything arriving here is a protocol error.
            if (layer_start_i || ip_result_valid_i) begin
               w_err_nxt = 1'b1;
            end
            w_wr_bank_nxt = ~r_wr_bank;
            w_state_nxt   = ST_IDLE;
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Registers. busy/layer_done are derived from the next state so they
   // line up with the state they describe.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state      <= ST_IDLE;
         r_layer      <= 3'd0;
         r_neuron_pos <= '0;
         r_wr_en      <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
         r_wr_bank    <= 1'b0;
         r_busy       <= 1'b0;
         r_layer_done <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_layer      <= w_layer_nxt;
         r_neuron_pos <= w_neuron_pos_nxt;
         r_wr_en      <= w_wr_en_nxt;
         r_wr_addr    <= w_wr_addr_nxt;
         r_wr_data    <= w_wr_data_nxt;
         r_wr_bank    <= w_wr_bank_nxt;
         r_busy       <= (w_state_nxt == ST_WRITE);
         r_layer_done <= (w_state_nxt == ST_DONE);
         r_err        <= w_err_nxt;
      end
   end

   assign wr_en_o      = r_wr_en;
   assign wr_addr_o    = r_wr_addr;
   assign wr_data_o    = r_wr_data;
   assign wr_bank_o    = r_wr_bank;
   assign busy_o       = r_busy;
   assign layer_done_o = r_layer_done;
   assign err_o        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ip_wr_data.sv
`default_nettype none
// ============================================================================
// Module   : tb_ip_wr_data
// Purpose  : Self-checking bench for ip_wr_data. A behavioural model keeps
//            the expected bank, error flag and last write address; every
//            cycle the full output vector is compared against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ip_wr_data;

   logic        clk_i = 1'b0;
   logic        rstn_i;
   logic [2:0]  cur_layer_index_i;
   logic        layer_start_i;
   logic        ip_result_valid_i;
   logic [31:0] ip_result_i;
   logic        wr_en_o;
   logic [14:0] wr_addr_o;
   logic [31:0] wr_data_o;
   logic        wr_bank_o;
   logic        busy_o;
   logic        layer_done_o;
   logic        err_o;

   int checks   = 0;
   int failures = 0;

   // Model state
   logic        m_bank;
   logic        m_err;
   logic [14:0] m_addr;

   ip_wr_data #(.FW(32), .AW(15)) dut (
      .clk_i             (clk_i),
      .rstn_i            (rstn_i),
      .cur_layer_index_i (cur_layer_index_i),
      .layer_start_i     (layer_start_i),
      .ip_result_valid_i (ip_result_valid_i),
      .ip_result_i       (ip_result_i),
      .wr_en_o           (wr_en_o),
      .wr_addr_o         (wr_addr_o),
      .wr_data_o         (wr_data_o),
      .wr_bank_o         (wr_bank_o),
      .busy_o            (busy_o),
      .layer_done_o      (layer_done_o),
      .err_o             (err_o)
   );

   always #5 clk_i = ~clk_i;

   // Number of results a layer consumes.
   function automatic int layer_len(input int idx);
      case (idx)
         0, 2:    return 256;
         1, 3:    return 4096;
         4, 5:    return 1000;
         default: return 1;
      endcase
   endfunction

   // {wr_en, wr_bank, busy, layer_done, err, wr_addr, wr_data}
   function automatic logic [51:0] outs();
      return {wr_en_o, wr_bank_o, busy_o, layer_done_o, err_o, wr_addr_o, wr_data_o};
   endfunction

   function automatic logic [51:0] pack(input bit en, input bit busy,
                                        input bit done, input logic [31:0] d);
      return {en, m_bank, busy, done, m_err, m_addr, d};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Inactive inputs; index and data are scrambled to show they are ignored.
   task automatic idle_inputs();
      layer_start_i     = 1'b0;
      ip_result_valid_i = 1'b0;
      ip_result_i       = $urandom;
      cur_layer_index_i = 3'($urandom_range(7));
   endtask

   task automatic do_reset();
      idle_inputs();
      rstn_i = 1'b0;
      #1;
      m_bank = 1'b0;
      m_err  = 1'b0;
      m_addr = '0;
      chk("reset", outs(), pack(0, 0, 0, 32'd0));
      tick();
      rstn_i = 1'b1;
   endtask

   // Runs one layer. mode: 0 = value k, 1 = alternating -10/10, 2 = random.
   // bad_at: write index before which a stray start is injected (-1 none).
   // start_valid: drive a valid together with the start pulse.
   // done_junk: drive start+valid during the DONE cycle.
   // abort_after: return (still mid-layer) after that many writes (-1 none).
   task automatic run_layer(input int idx, input int gap_pct, input int mode,
                            input int bad_at, input bit start_valid,
                            input bit done_junk, input int abort_after);
      int          n;
      int          sent;
      bit          v;
      bit          last;
      bit          bad_done;
      logic [31:0] x;
      logic [31:0] e_data;
      n        = layer_len(idx);
      sent     = 0;
      bad_done = 1'b0;

      layer_start_i     = 1'b1;
      cur_layer_index_i = 3'(idx);
      ip_result_valid_i = start_valid;
      ip_result_i       = $urandom;
      tick();
      idle_inputs();
      if (start_valid) m_err = 1'b1;
      chk("start", outs(), pack(0, 1, 0, 32'd0));

      while (sent < n) begin
         if (abort_after >= 0 && sent == abort_after) return;
         if (bad_at >= 0 && sent == bad_at && !bad_done) begin
            bad_done          = 1'b1;
            layer_start_i     = 1'b1;
            cur_layer_index_i = 3'((idx + 3) % 8);
            tick();
            idle_inputs();
            m_err = 1'b1;
            chk("bad_start", outs(), pack(0, 1, 0, 32'd0));
            continue;
         end
         v = (gap_pct == 0) || ($urandom_range(99) >= gap_pct);
         case (mode)
            0:       x = 32'(sent);
            1:       x = sent[0] ? 32'd10 : 32'hFFFF_FFF6;
            default: x = $urandom;
         endcase
         ip_result_valid_i = v;
         ip_result_i       = v ? x : $urandom;
         tick();
         idle_inputs();
         if (v) begin
            m_addr = 15'(sent);
            e_data = (idx <= 4 && x[31]) ? 32'd0 : x;
            sent++;
            last = (sent == n);
            chk("write", outs(), pack(1, !last, last, e_data));
         end else begin
            chk("gap", outs(), pack(0, 1, 0, 32'd0));
         end
      end

      if (done_junk) begin
         layer_start_i     = 1'b1;
         ip_result_valid_i = 1'b1;
      end
      tick();
      idle_inputs();
      m_bank = ~m_bank;
      if (done_junk) m_err = 1'b1;
      chk("after_done", outs(), pack(0, 0, 0, 32'd0));
   endtask

   initial begin
      rstn_i = 1'b1;
      idle_inputs();
      #2;
      do_reset();

      // Clean layer 0: values k at addresses k, bank flips, no error.
      run_layer(0, 0, 0, -1, 0, 0, -1);
      chk("bank_after_l0", 64'(wr_bank_o), 64'd1);
      chk("err_clean", 64'(err_o), 64'd0);

      // ReLU on layer 2, pass-through on classifier layer 5.
      run_layer(2, 0, 1, -1, 0, 0, -1);
      run_layer(5, 0, 1, -1, 0, 0, -1);

      // Layer 4 with random gaps and random data.
      run_layer(4, 30, 2, -1, 0, 0, -1);

      // Valid while idle: dropped, error raised.
      do_reset();
      ip_result_valid_i = 1'b1;
      ip_result_i       = $urandom;
      tick();
      idle_inputs();
      m_err = 1'b1;
      chk("idle_valid", outs(), pack(0, 0, 0, 32'd0));

      // Stray start mid-layer: counter and layer unaffected.
      do_reset();
      run_layer(2, 10, 2, 10, 0, 0, -1);

      // Valid coinciding with start.
      do_reset();
      run_layer(6, 0, 2, -1, 1, 0, -1);

      // Start and valid during DONE.
      do_reset();
      run_layer(7, 0, 2, -1, 0, 1, -1);

      // Bank ping-pong over layers 0..5.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         chk("bank_seq", 64'(wr_bank_o), 64'(i % 2));
         run_layer(i, 0, 2, -1, 0, 0, -1);
      end
      chk("bank_end", 64'(wr_bank_o), 64'd0);

      // Asynchronous reset mid-layer (bank is 1 beforehand).
      run_layer(6, 0, 2, -1, 0, 0, -1);
      run_layer(1, 0, 2, -1, 0, 0, 100);
      #2;
      rstn_i = 1'b0;
      #1;
      chk("rst_async", 64'(outs()), 64'd0);
      m_bank = 1'b0;
      m_err  = 1'b0;
      m_addr = '0;
      tick();
      rstn_i = 1'b1;
      run_layer(0, 0, 2, -1, 0, 0, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ip_wr_data.md
# ip_wr_data

Inner-product result writer for the FC engine. Takes output-neuron results from the inner-product accumulator, applies ReLU on hidden layers, and writes them sequentially into the ping-pong activation BRAM. The next FC layer's input reader then fetches them with its own address walk. Tracks the per-layer neuron count, flips the ping-pong bank at layer end, and flags protocol violations.

## Interface
- FW, 32, result/data word width (two's complement)
- AW, 15, BRAM address width
- clk_i  in  1  clock, all logic on rising edge
- rstn_i  in  1  asynchronous active-low reset
- cur_layer_index_i  in  3  FC layer index (0..5), sampled only on layer_start_i
- layer_start_i  in  1  one-cycle pulse arming the writer for a new layer
- ip_result_valid_i  in  1  result word valid this cycle
- ip_result_i  in  FW  neuron result
- wr_en_o  out  1  BRAM write enable
- wr_addr_o  out  AW  BRAM write address
- wr_data_o  out  FW  BRAM write data
- wr_bank_o  out  1  ping-pong bank being written
- busy_o  out  1  high while armed (WRITE state)
- layer_done_o  out  1  one-cycle pulse after the last write of a layer
- err_o  out  1  sticky protocol error

## Operation
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - On layer_start_i, latch cur_layer_index_i into layer_q, clear neuron_pos, go to WRITE.
  - ip_result_valid_i in IDLE is dropped (no write) and sets err_o.
- neuron_end from layer_q: 0→255, 1→4095, 2→255, 3→4095, 4→999, 5→999, 6/7→0.
- WRITE:
  - Each ip_result_valid_i produces exactly one write at address {3'd0, neuron_pos}, then neuron_pos increments.
  - When a valid arrives with neuron_pos == neuron_end, perform the write, clear neuron_pos, and go to DONE.
- DONE (exactly one cycle): layer_done_o = 1, then go to IDLE. wr_bank_o toggles on the DONE→IDLE edge.
- Data path:
  - layer_q in 0..4: ReLU, wr_data_o = ip_result_i[FW-1] ? 0 : ip_result_i.
  - layer_q == 5 (classifier): pass-through.
  - 6/7: pass-through.
- Ignored inputs:
  - layer_start_i while in WRITE or DONE is ignored and sets err_o.
  - cur_layer_index_i changes outside a start pulse have no effect.
  - ip_result_valid_i while in DONE is dropped and sets err_o.
- err_o stays high until reset.
- neuron_pos is 12 bits. It never exceeds neuron_end, so no wrap-around beyond neuron_end.

## Timing
- Reset values: wr_en_o=0, wr_addr_o=0, wr_data_o=0, wr_bank_o=0, busy_o=0, layer_done_o=0, err_o=0, state IDLE, neuron_pos=0, layer_q=0.
- All outputs are registered.
- Write latency:
  - A valid sampled at edge t gives wr_en_o/wr_addr_o/wr_data_o at cycle t+1, held for one cycle.
  - When no valid is sampled, wr_en_o=0 and wr_data_o=0 the next cycle. wr_addr_o holds its last value.
- Throughput: one result per cycle, back-to-back, no stall; gaps allowed.
- Start: layer_start_i sampled at edge t sets busy_o=1 from cycle t+1. A valid in the same cycle as layer_start_i is treated as an IDLE valid: dropped, err_o set.
- Final write at cycle t+1 → DONE in cycle t+1 → layer_done_o=1 and busy_o=0 in cycle t+1. wr_bank_o shows the new bank from cycle t+2.
- The earliest next layer_start_i accepted is the cycle layer_done_o is high (sampled in DONE): ignored with err_o. It must come at cycle t+2 or later.
- Reset mid-layer returns everything to reset values immediately, including wr_bank_o=0. A partial layer is abandoned.

## Test plan
- Layer 0 clean run: start with index 0, 256 back-to-back valids of value k → writes addr 0..255, one per cycle; layer_done_o pulses one cycle after the last write; wr_bank_o 0→1; err_o=0.
- ReLU/pass-through: layer 2, results alternating 32'hFFFF_FFF6 / 32'd10 → wr_data_o 0 / 10. Then layer 5 with the same stimulus → FFFF_FFF6 / 10 unchanged.
- Gapped valids: layer 4, 1000 valids with random idle cycles → exactly 1000 writes, addr 0..999 in order; layer_done_o fires once; no write when valid is low.
- Protocol errors:
  - Valid in IDLE → no write, err_o=1.
  - Second layer_start_i mid-WRITE → ignored, counter unchanged, err_o=1.
- Bank ping-pong: six consecutive layers 0..5 → wr_bank_o sequence 0,1,0,1,0,1, ending at 0 after layer 5.
- Async reset: assert rstn_i low after 100 writes of layer 1 → all outputs 0 within the reset cycle. A new start then writes from addr 0 on bank 0.
